// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch / prefetch slice.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage : fetch_pkg

// File: rtl/sync_fifo.sv
// Small register-based FIFO with push/pop/flush and occupancy count.
// Head entry is read straight from storage so a pushed word is visible the next cycle.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [DEPTH-1:0] wr_en;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push_ok && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) mem_reg[i] <= push_data;
      end
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data = mem_reg[rd_ptr_reg];
  assign count     = count_reg;

endmodule : sync_fifo

// File: rtl/fetch_prefetch_unit.sv
// PC register, next-PC selection, RUN/HALT control and prefetch queue in front of decode.
// Redirects flush the queue and restart fetch at the word-aligned target.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int          DEPTH    = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               halt_req,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    fetch_pc,
  output logic [CNT_W-1:0]   count,
  output logic               halted
);

  localparam int ENTRY_W = XLEN + INSTR_W;

  fetch_state_t          state_reg;
  logic [XLEN-1:0]       fetch_pc_reg;
  logic [XLEN-1:0]       fetch_pc_next;
  logic [XLEN-1:0]       redirect_target;
  logic [ENTRY_W-1:0]    head_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;

  assign imem_req  = (state_reg == RUN) && !fifo_full && !rst;
  assign push      = imem_req && imem_ack && !redirect_valid;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready && !redirect_valid;

  // Low two bits are forced to zero so targets are always word aligned.
  assign redirect_target = redirect_pc & ~XLEN'(3);

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (push) fetch_pc_next = fetch_pc_reg + XLEN'(PC_STEP);
  end

  // Redirect outranks halt, so a simultaneous halt request leaves the unit running.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RUN;
      fetch_pc_reg <= RESET_PC;
    end else if (redirect_valid) begin
      state_reg    <= RUN;
      fetch_pc_reg <= redirect_target;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      case (state_reg)
        RUN:     if (halt_req) state_reg <= HALT;
        HALT:    state_reg <= HALT;
        default: state_reg <= RUN;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({fetch_pc_reg, imem_rdata}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (head_data),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_pc    = head_data[ENTRY_W-1:INSTR_W];
  assign out_instr = head_data[INSTR_W-1:0];
  assign imem_addr = fetch_pc_reg;
  assign fetch_pc  = fetch_pc_reg;
  assign halted    = (state_reg == HALT);

endmodule : fetch_prefetch_unit
